multiword_adder_seq: RTL



---
 rtl/multiword_adder_seq_pkg.sv | 12 +
 rtl/hybrid.sv | 25 ++
 rtl/multiword_adder_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/multiword_adder_seq_pkg.sv
// rtl/multiword_adder_seq_pkg.sv - shared constants for the sequential multi-byte adder
package multiword_adder_seq_pkg;

  // Datapath slice width handled per clock
  localparam int BYTE_W = 8;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/hybrid.sv
// rtl/hybrid.sv - 8-bit adder: ripple low nibble, carry-select high nibble
module hybrid
  import multiword_adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              c_in,
  output logic [BYTE_W-1:0] sum,
  output logic              c_out
);

  logic [4:0] lo;
  logic [4:0] hi_c0;
  logic [4:0] hi_c1;

  // Low nibble resolves the carry that selects between the two precomputed high nibbles
  always_comb begin
    lo    = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, c_in};
    hi_c0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi_c1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    sum   = lo[4] ? {hi_c1[3:0], lo[3:0]} : {hi_c0[3:0], lo[3:0]};
    c_out = lo[4] ? hi_c1[4] : hi_c0[4];
  end

endmodule

// File: rtl/multiword_adder_seq.sv
// rtl/multiword_adder_seq.sv - adds WORDS-byte operands one byte per clock through hybrid
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int WORDS = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BYTE_W*WORDS-1:0] a,
  input  logic [BYTE_W*WORDS-1:0] b,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [BYTE_W*WORDS-1:0] sum,
  output logic                  c_out,
  output logic                  zero
);

  localparam int W     = BYTE_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;

  logic [BYTE_W-1:0] h_sum;
  logic              h_cout;
  logic [W-1:0]      res_shift;

  hybrid u_hybrid (
    .a     (opa_q[BYTE_W-1:0]),
    .b     (opb_q[BYTE_W-1:0]),
    .c_in  (carry_q),
    .sum   (h_sum),
    .c_out (h_cout)
  );

  // Result fills from the top so byte 0 lands at the bottom after WORDS shifts
  assign res_shift = {h_sum, res_q[W-1:BYTE_W]};

  // Next-state: accept start whenever not adding, otherwise step one byte per cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    zero_d  = zero_q;
    case (state_q)
      ST_ADD: begin
        opa_d   = opa_q >> BYTE_W;
        opb_d   = opb_q >> BYTE_W;
        res_d   = res_shift;
        carry_d = h_cout;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          sum_d   = res_shift;
          c_out_d = h_cout;
          zero_d  = (res_shift == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_ADD;
          opa_d   = a;
          opb_d   = b;
          carry_d = c_in;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and result registers; reset discards any partial result at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = (state_q == ST_ADD);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign zero  = zero_q;

endmodule
